// File: rtl/pipelined_main_control.sv
// pipelined_main_control
//   ID-stage control unit for the 5-stage pipelined CPU. Decodes the opcode
//   into per-stage flags and one-hot branch/jump strobes, carries the flags
//   down a chain of stage registers (stage 0 = EX), and sequences LDW/SDW as
//   two back-to-back micro-ops by holding the PC for one cycle.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   opcode                opcode of the instruction in IF/ID
//   valid_in              IF/ID holds a real instruction
//   stall / flush         load-use bubble / kill ID instruction
//   turn_off              halt request (exit only by reset)
//   id_flags              decoded, gated flags of the current ID micro-op
//   stage_flags           stage k at [k*FLAG_W +: FLAG_W]
//   bz..call              one-hot branch-type strobes (gated)
//   pc_hold               freeze PC and IF/ID (first LDW/SDW micro-op)
//   dw_second             current ID micro-op is the second word
//   halted                in HALT state
//   illegal_op/_seen      only with ILLEGAL_TRAP_EN defined
//
// Optional feature macro: ILLEGAL_TRAP_EN
module pipelined_main_control #(
  parameter int unsigned         OPCODE_W   = 6,
  parameter int unsigned         FLAG_W     = 8,
  parameter int unsigned         PIPE_DEPTH = 3,
  parameter logic [OPCODE_W-1:0] DW_LD_OPC  = 'h08,
  parameter logic [OPCODE_W-1:0] DW_ST_OPC  = 'h09
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [OPCODE_W-1:0]          opcode,
  input  logic                         valid_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         turn_off,
  output logic [FLAG_W-1:0]            id_flags,
  output logic [PIPE_DEPTH*FLAG_W-1:0] stage_flags,
  output logic                         bz,
  output logic                         bgz,
  output logic                         blz,
  output logic                         jr,
  output logic                         jump,
  output logic                         call,
  output logic                         pc_hold,
  output logic                         dw_second,
`ifdef ILLEGAL_TRAP_EN
  output logic                         illegal_op,
  output logic                         illegal_seen,
`endif
  output logic                         halted
);

  typedef enum logic [1:0] {RUN, DW2, HALT} state_t;

  state_t             state, state_nxt;
  logic               op_defined;
  logic               is_dw;
  logic               gate;
  logic [7:0]         raw_flags;
  logic [5:0]         raw_strobe;
  logic [FLAG_W-1:0]  stage_q [PIPE_DEPTH];

  assign op_defined = ((opcode >> 4) == '0);
  assign is_dw      = op_defined && (opcode == DW_LD_OPC || opcode == DW_ST_OPC);

  always_comb begin
    raw_flags  = '0;
    raw_strobe = '0;
    if (op_defined) begin
      if (opcode == DW_LD_OPC) begin
        raw_flags = 8'h3D;
      end else if (opcode == DW_ST_OPC) begin
        raw_flags = 8'h5A;
      end else begin
        case (opcode[3:0])
          4'h0, 4'h1, 4'h2, 4'h3: raw_flags = 8'h20;
          4'h4, 4'h5:             raw_flags = 8'h38;
          4'h6:                   raw_flags = 8'h3D;
          4'h7:                   raw_flags = 8'h5A;
          4'hA: begin raw_flags = 8'h98; raw_strobe = 6'b100000; end
          4'hB: begin raw_flags = 8'h98; raw_strobe = 6'b010000; end
          4'hC: begin raw_flags = 8'h98; raw_strobe = 6'b001000; end
          4'hD: begin raw_flags = 8'h98; raw_strobe = 6'b000100; end
          4'hE:                   raw_strobe = 6'b000010;
          4'hF:                   raw_strobe = 6'b000001;
          default:                raw_flags = 8'h00;
        endcase
      end
    end
  end

  assign gate     = valid_in && !stall && !flush && (state != HALT);
  assign id_flags = gate ? FLAG_W'(raw_flags) : '0;
  assign {bz, bgz, blz, jr, jump, call} = gate ? raw_strobe : 6'b000000;

  assign halted    = (state == HALT);
  assign dw_second = (state == DW2);
  // pc_hold mirrors exactly the RUN->DW2 transition condition
  assign pc_hold   = (state == RUN) && valid_in && is_dw && !stall && !flush && !turn_off;

  always_comb begin
    state_nxt = state;
    if (turn_off) begin
      state_nxt = HALT;
    end else begin
      case (state)
        RUN:     if (valid_in && is_dw && !stall && !flush) state_nxt = DW2;
        DW2:     if (flush || !stall) state_nxt = RUN;
        HALT:    state_nxt = HALT;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Stage chain is never frozen: bubbles come from the already-gated id_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= id_flags;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage_out
    assign stage_flags[g*FLAG_W +: FLAG_W] = stage_q[g];
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = valid_in && (state != HALT) && !op_defined;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           illegal_seen <= 1'b0;
    else if (illegal_op) illegal_seen <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipelined_main_control.sv
module tb_pipelined_main_control;

  localparam int FW = 8;
  localparam int PD = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic          valid_in = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          turn_off = 1'b0;
  logic [FW-1:0] id_flags;
  logic [PD*FW-1:0] stage_flags;
  logic          bz, bgz, blz, jr, jump, call;
  logic          pc_hold, dw_second, halted;
`ifdef ILLEGAL_TRAP_EN
  logic          illegal_op, illegal_seen;
`endif

  int total = 0;
  int bad = 0;

  pipelined_main_control #(
    .OPCODE_W(6), .FLAG_W(FW), .PIPE_DEPTH(PD),
    .DW_LD_OPC(6'h08), .DW_ST_OPC(6'h09)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .valid_in(valid_in),
    .stall(stall), .flush(flush), .turn_off(turn_off),
    .id_flags(id_flags), .stage_flags(stage_flags),
    .bz(bz), .bgz(bgz), .blz(blz), .jr(jr), .jump(jump), .call(call),
    .pc_hold(pc_hold), .dw_second(dw_second),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op(illegal_op), .illegal_seen(illegal_seen),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       v;
    logic       st;
    logic       fl;
    logic [7:0] exp_flags;
    logic [5:0] exp_strobe;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stg(input int k);
    return stage_flags[k*FW +: FW];
  endfunction

  task automatic idle;
    opcode = '0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; turn_off = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{6'h00, 1, 0, 0, 8'h20, 6'b000000};
    vecs[1]  = '{6'h03, 1, 0, 0, 8'h20, 6'b000000};
    vecs[2]  = '{6'h04, 1, 0, 0, 8'h38, 6'b000000};
    vecs[3]  = '{6'h05, 1, 0, 0, 8'h38, 6'b000000};
    vecs[4]  = '{6'h06, 1, 0, 0, 8'h3D, 6'b000000};
    vecs[5]  = '{6'h07, 1, 0, 0, 8'h5A, 6'b000000};
    vecs[6]  = '{6'h0A, 1, 0, 0, 8'h98, 6'b100000};
    vecs[7]  = '{6'h0B, 1, 0, 0, 8'h98, 6'b010000};
    vecs[8]  = '{6'h0C, 1, 0, 0, 8'h98, 6'b001000};
    vecs[9]  = '{6'h0D, 1, 0, 0, 8'h98, 6'b000100};
    vecs[10] = '{6'h0E, 1, 0, 0, 8'h00, 6'b000010};
    vecs[11] = '{6'h0F, 1, 0, 0, 8'h00, 6'b000001};
    vecs[12] = '{6'h10, 1, 0, 0, 8'h00, 6'b000000};
    vecs[13] = '{6'h3F, 1, 0, 0, 8'h00, 6'b000000};
    vecs[14] = '{6'h01, 0, 0, 0, 8'h00, 6'b000000};
    vecs[15] = '{6'h0A, 1, 1, 0, 8'h00, 6'b000000};
    vecs[16] = '{6'h0D, 1, 0, 1, 8'h00, 6'b000000};
    vecs[17] = '{6'h08, 1, 1, 0, 8'h00, 6'b000000};
    vecs[18] = '{6'h09, 1, 0, 1, 8'h00, 6'b000000};
    vecs[19] = '{6'h0F, 1, 1, 1, 8'h00, 6'b000000};

    #12;
    reset = 1'b0;
    #1;
    check("reset_stage", 32'(stage_flags), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_dw_second", 32'(dw_second), 32'h0);
    check("reset_pc_hold", 32'(pc_hold), 32'h0);

    // Combinational decode and gating table (none of these leaves RUN)
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = vecs[i].op; valid_in = vecs[i].v; stall = vecs[i].st; flush = vecs[i].fl;
      #1;
      check($sformatf("vec%0d_flags", i), 32'(id_flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d_strobe", i), 32'({bz, bgz, blz, jr, jump, call}), 32'(vecs[i].exp_strobe));
      check($sformatf("vec%0d_pc_hold", i), 32'(pc_hold), 32'h0);
    end

    // 1: ADD latency through the chain
    do_reset();
    opcode = 6'h01; valid_in = 1'b1;
    #1;
    check("add_id", 32'(id_flags), 32'h20);
    tick();
    idle();
    check("add_stage0", 32'(stg(0)), 32'h20);
    tick();
    check("add_stage1", 32'(stg(1)), 32'h20);
    check("add_stage0_bubble", 32'(stg(0)), 32'h0);
    tick();
    check("add_stage2", 32'(stg(2)), 32'h20);

    // 2: LDW, no stall
    do_reset();
    opcode = 6'h08; valid_in = 1'b1;
    #1;
    check("ldw_c0_pc_hold", 32'(pc_hold), 32'h1);
    check("ldw_c0_id", 32'(id_flags), 32'h3D);
    check("ldw_c0_dw2", 32'(dw_second), 32'h0);
    tick();
    check("ldw_c1_dw2", 32'(dw_second), 32'h1);
    check("ldw_c1_pc_hold", 32'(pc_hold), 32'h0);
    check("ldw_c1_id", 32'(id_flags), 32'h3D);
    check("ldw_c1_stage0", 32'(stg(0)), 32'h3D);
    tick();
    idle();
    check("ldw_c2_stage0", 32'(stg(0)), 32'h3D);
    check("ldw_c2_stage1", 32'(stg(1)), 32'h3D);
    check("ldw_c2_dw2", 32'(dw_second), 32'h0);

    // 3: LW then one stall cycle with BZ held
    do_reset();
    opcode = 6'h06; valid_in = 1'b1;
    tick();
    check("lw_stage0", 32'(stg(0)), 32'h3D);
    opcode = 6'h0A; stall = 1'b1;
    #1;
    check("stall_id", 32'(id_flags), 32'h0);
    check("stall_bz", 32'(bz), 32'h0);
    tick();
    check("stall_stage0", 32'(stg(0)), 32'h0);
    check("stall_stage1", 32'(stg(1)), 32'h3D);
    stall = 1'b0;
    #1;
    check("bz_id", 32'(id_flags), 32'h98);
    check("bz_strobe", 32'(bz), 32'h1);
    tick();
    idle();
    check("bz_stage0", 32'(stg(0)), 32'h98);
    check("bz_stage2", 32'(stg(2)), 32'h3D);

    // 4: LDW with flush in the DW2 cycle
    do_reset();
    opcode = 6'h08; valid_in = 1'b1;
    tick();
    flush = 1'b1;
    #1;
    check("flush_dw2_now", 32'(dw_second), 32'h1);
    check("flush_id", 32'(id_flags), 32'h0);
    tick();
    check("flush_stage0", 32'(stg(0)), 32'h0);
    check("flush_dw2_after", 32'(dw_second), 32'h0);
    idle();

    // SDW with stall in DW2: stays in DW2, bubble, then completes
    do_reset();
    opcode = 6'h09; valid_in = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    check("dw2_stall_hold", 32'(dw_second), 32'h1);
    check("dw2_stall_stage0", 32'(stg(0)), 32'h0);
    stall = 1'b0;
    #1;
    check("dw2_resume_id", 32'(id_flags), 32'h5A);
    tick();
    idle();
    check("dw2_resume_state", 32'(dw_second), 32'h0);
    check("dw2_resume_stage0", 32'(stg(0)), 32'h5A);

    // Reset mid-LDW drops the second micro-op
    do_reset();
    opcode = 6'h08; valid_in = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_dw2", 32'(dw_second), 32'h0);
    check("rst_mid_stage", 32'(stage_flags), 32'h0);
    reset = 1'b0;
    idle();

    // 5: turn_off during an ADDI stream
    do_reset();
    opcode = 6'h04; valid_in = 1'b1;
    tick();
    tick();
    turn_off = 1'b1;
    #1;
    check("toff_id_same_cycle", 32'(id_flags), 32'h38);
    tick();
    turn_off = 1'b0;
    #1;
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_id", 32'(id_flags), 32'h0);
    check("halt_stage0", 32'(stg(0)), 32'h38);
    opcode = 6'h08;
    #1;
    check("halt_no_pc_hold", 32'(pc_hold), 32'h0);
    for (int i = 0; i < PD; i++) tick();
    check("halt_drained", 32'(stage_flags), 32'h0);
    check("halt_sticky", 32'(halted), 32'h1);
    do_reset();
    check("halt_cleared", 32'(halted), 32'h0);

`ifdef ILLEGAL_TRAP_EN
    // 6: illegal opcode trap
    check("illegal_seen_rst", 32'(illegal_seen), 32'h0);
    opcode = 6'h15; valid_in = 1'b1;
    #1;
    check("illegal_op", 32'(illegal_op), 32'h1);
    tick();
    idle();
    #1;
    check("illegal_stage0", 32'(stg(0)), 32'h0);
    check("illegal_seen_set", 32'(illegal_seen), 32'h1);
    check("illegal_op_clear", 32'(illegal_op), 32'h0);
    tick();
    check("illegal_seen_sticky", 32'(illegal_seen), 32'h1);
    do_reset();
    check("illegal_seen_cleared", 32'(illegal_seen), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
